// File: rtl/pong_button_debounce_if.sv
// Button bundle between the raw Go Board switches and the debouncer.
// Latency: none (wires only).
// Backpressure: none; all signals are free-running levels or single-clock pulses.
// Signals:
//   switch_raw    raw, asynchronous, bouncing button levels (1 = pressed)
//   switch_level  debounced level per channel
//   press_pulse   1-clock pulse on an accepted 0->1 transition
//   release_pulse 1-clock pulse on an accepted 1->0 transition
interface pong_button_debounce_if #(
    parameter int NUM_BTNS = 4
);
    logic [NUM_BTNS-1:0] switch_raw;
    logic [NUM_BTNS-1:0] switch_level;
    logic [NUM_BTNS-1:0] press_pulse;
    logic [NUM_BTNS-1:0] release_pulse;

    // master: the button source side, which also consumes the clean results
    modport master (
        output switch_raw,
        input  switch_level,
        input  press_pulse,
        input  release_pulse
    );

    // slave: the debouncer itself
    modport slave (
        input  switch_raw,
        output switch_level,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/pong_button_debounce.sv
// Debounces the paddle push-buttons: 2-flop synchronizer plus stability counter per channel,
// producing a clean level and registered single-clock press/release pulses.
// Latency: LIMIT+2 clocks from a clean raw edge to the level/pulse; no backpressure (free-running).
// Ports:
//   i_Clk  system clock (25 MHz pixel domain)
//   i_Rst  asynchronous active-high reset; clears sync flops, counters, level and pulses at once
//   btn    slave side of pong_button_debounce_if (raw switches in; level, press, release out)
module pong_button_debounce #(
    parameter int c_NUM_BTNS       = 4,
    parameter int c_DEBOUNCE_LIMIT = 250000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    pong_button_debounce_if.slave  btn
);
    localparam int            CW   = $clog2(c_DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] LAST = CW'(c_DEBOUNCE_LIMIT - 1);

    // The level is encoded in the state: STABLE_HI and QUAL_LO both read as 1.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } state_t;

    logic [c_NUM_BTNS-1:0] sync1;
    logic [c_NUM_BTNS-1:0] sync2;
    logic [c_NUM_BTNS-1:0] level;
    logic [c_NUM_BTNS-1:0] press;
    logic [c_NUM_BTNS-1:0] rel;

    // Raw buttons are asynchronous to i_Clk; only sync2 is trusted downstream.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn.switch_raw;
            sync2 <= sync1;
        end
    end

    for (genvar n = 0; n < c_NUM_BTNS; n++) begin : g_chan
        state_t        state_q;
        state_t        state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          press_q;
        logic          press_d;
        logic          rel_q;
        logic          rel_d;

        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        // The counter holds the number of consecutive clocks sync2 has disagreed with the
        // level. Any agreement drops back to 0, so a bounce discards all progress; the
        // LIMIT-th disagreeing clock flips the level instead of counting past LIMIT-1.
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            press_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                STABLE_LO: begin
                    if (sync2[n]) begin
                        state_d = QUAL_HI;
                        cnt_d   = CW'(1);
                    end
                end
                QUAL_HI: begin
                    if (!sync2[n]) begin
                        state_d = STABLE_LO;
                    end else if (cnt_q == LAST) begin
                        state_d = STABLE_HI;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync2[n]) begin
                        state_d = QUAL_LO;
                        cnt_d   = CW'(1);
                    end
                end
                QUAL_LO: begin
                    if (sync2[n]) begin
                        state_d = STABLE_HI;
                    end else if (cnt_q == LAST) begin
                        state_d = STABLE_LO;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = STABLE_LO;
                end
            endcase
        end

        assign level[n] = (state_q == STABLE_HI) || (state_q == QUAL_LO);
        assign press[n] = press_q;
        assign rel[n]   = rel_q;
    end

    assign btn.switch_level  = level;
    assign btn.press_pulse   = press;
    assign btn.release_pulse = rel;
endmodule

// File: tb/tb_pong_button_debounce.sv
// Self-checking bench for pong_button_debounce with LIMIT = 4 and four channels.
// Latency: n/a (bench).
// Backpressure: n/a; inputs change on the falling clock edge, outputs are read there too.
module tb_pong_button_debounce;
    localparam int N   = 4;
    localparam int LIM = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] raw;
    int           checks;
    int           errors;

    pong_button_debounce_if #(.NUM_BTNS(N)) bif ();
    assign bif.switch_raw = raw;

    pong_button_debounce #(
        .c_NUM_BTNS      (N),
        .c_DEBOUNCE_LIMIT(LIM)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .btn  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a raw sample taken at a rising edge becomes visible to the
    // qualification logic two edges later (zero right after reset). A channel flips when
    // at least LIM edges have passed since its last change/reset and the last LIM visible
    // values all differ from its current level.
    logic [N-1:0] m_sw;
    logic [N-1:0] m_press;
    logic [N-1:0] m_rel;
    logic [N-1:0] raw_q[$];
    logic [N-1:0] seen_hist[$];
    int           since_change[N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q.delete();
            seen_hist.delete();
            m_sw    = '0;
            m_press = '0;
            m_rel   = '0;
            for (int c = 0; c < N; c++) since_change[c] = 0;
        end else begin
            logic [N-1:0] seen;
            raw_q.push_back(bif.switch_raw);
            seen = (raw_q.size() >= 3) ? raw_q[raw_q.size()-3] : '0;
            if (raw_q.size() > 3) void'(raw_q.pop_front());
            seen_hist.push_back(seen);
            if (seen_hist.size() > LIM) void'(seen_hist.pop_front());
            m_press = '0;
            m_rel   = '0;
            for (int c = 0; c < N; c++) begin
                bit ok;
                since_change[c]++;
                ok = (since_change[c] >= LIM) && (seen_hist.size() == LIM);
                if (ok) begin
                    for (int k = 0; k < LIM; k++)
                        if (seen_hist[k][c] == m_sw[c]) ok = 0;
                end
                if (ok) begin
                    if (m_sw[c]) m_rel[c] = 1'b1;
                    else         m_press[c] = 1'b1;
                    m_sw[c] = ~m_sw[c];
                    since_change[c] = 0;
                end
            end
        end
    end

    task automatic settle();
        raw = '0;
        repeat (LIM + 5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw = '0;
        #2;
        checks++;
        if ({bif.switch_level, bif.press_pulse, bif.release_pulse} !== 12'h000) begin
            errors++;
            $display("FAIL reset_initial: got %h want 000",
                     {bif.switch_level, bif.press_pulse, bif.release_pulse});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        raw = '1;
        repeat (LIM + 4) @(negedge clk);
        checks++;
        if (bif.switch_level !== 4'hF) begin
            errors++;
            $display("FAIL reset_precondition: level got %b want 1111", bif.switch_level);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bif.switch_level, bif.press_pulse, bif.release_pulse} !== 12'h000) begin
            errors++;
            $display("FAIL reset_async_clear: got %h want 000 before any clock edge",
                     {bif.switch_level, bif.press_pulse, bif.release_pulse});
        end
        raw = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        settle();
    endtask

    task automatic test_clean_press();
        @(negedge clk);
        raw[0] = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            checks++;
            if (bif.switch_level[0] !== (j >= 5)) begin
                errors++;
                $display("FAIL clean_press_level after edge %0d: got %b want %b",
                         j, bif.switch_level[0], (j >= 5));
            end
            checks++;
            if (bif.press_pulse[0] !== (j == 5)) begin
                errors++;
                $display("FAIL clean_press_pulse after edge %0d: got %b want %b",
                         j, bif.press_pulse[0], (j == 5));
            end
        end
        settle();
    endtask

    task automatic test_bounce();
        @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            raw[1] = (j < 8) ? ((j % 2) == 0) : 1'b0;
            @(negedge clk);
            checks++;
            if ({bif.switch_level[1], bif.press_pulse[1], bif.release_pulse[1]} !== 3'b000) begin
                errors++;
                $display("FAIL bounce_ch1 cycle %0d: level/press/release got %b want 000", j,
                         {bif.switch_level[1], bif.press_pulse[1], bif.release_pulse[1]});
            end
        end
        settle();
    endtask

    task automatic test_glitch();
        @(negedge clk);
        raw[2] = 1'b1;
        for (int j = 0; j <= 11; j++) begin
            @(negedge clk);
            checks++;
            if (bif.switch_level[2] !== (j >= 9)) begin
                errors++;
                $display("FAIL glitch_level after edge %0d: got %b want %b",
                         j, bif.switch_level[2], (j >= 9));
            end
            checks++;
            if (bif.press_pulse[2] !== (j == 9)) begin
                errors++;
                $display("FAIL glitch_pulse after edge %0d: got %b want %b",
                         j, bif.press_pulse[2], (j == 9));
            end
            raw[2] = (j + 1 == 3) ? 1'b0 : 1'b1;
        end
        settle();
    endtask

    task automatic test_release_parallel();
        logic [N-1:0] prev_level;
        int           found;
        @(negedge clk);
        raw = 4'b1001;
        repeat (LIM + 5) @(negedge clk);
        checks++;
        if (bif.switch_level !== 4'b1001) begin
            errors++;
            $display("FAIL parallel_hold_level: got %b want 1001", bif.switch_level);
        end
        raw = 4'b0000;
        prev_level = bif.switch_level;
        found = -1;
        for (int j = 0; j < 16 && found < 0; j++) begin
            @(negedge clk);
            if (bif.release_pulse !== 4'b0000) begin
                found = j;
                checks++;
                if (bif.release_pulse !== 4'b1001) begin
                    errors++;
                    $display("FAIL parallel_release_pulse: got %b want 1001", bif.release_pulse);
                end
                checks++;
                if (prev_level !== 4'b1001 || bif.switch_level !== 4'b0000) begin
                    errors++;
                    $display("FAIL parallel_release_level: before %b after %b want 1001 then 0000",
                             prev_level, bif.switch_level);
                end
                checks++;
                if (j != 5) begin
                    errors++;
                    $display("FAIL parallel_release_timing: pulse after edge %0d want 5", j);
                end
            end
            prev_level = bif.switch_level;
        end
        checks++;
        if (found < 0) begin
            errors++;
            $display("FAIL parallel_release_timeout: no release pulse within 16 clocks, want 1001");
        end else begin
            @(negedge clk);
            checks++;
            if (bif.release_pulse !== 4'b0000) begin
                errors++;
                $display("FAIL parallel_release_width: got %b want 0000", bif.release_pulse);
            end
        end
        settle();
    endtask

    task automatic test_reset_midqual();
        @(negedge clk);
        raw[0] = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if ({bif.switch_level[0], bif.press_pulse[0]} !== 2'b00) begin
                errors++;
                $display("FAIL midqual_during_reset %0d: level/press got %b want 00", j,
                         {bif.switch_level[0], bif.press_pulse[0]});
            end
            @(negedge clk);
        end
        rst = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            checks++;
            if (bif.press_pulse[0] !== (j == 6)) begin
                errors++;
                $display("FAIL midqual_pulse after edge %0d from release: got %b want %b",
                         j, bif.press_pulse[0], (j == 6));
            end
            checks++;
            if (bif.switch_level[0] !== (j >= 6)) begin
                errors++;
                $display("FAIL midqual_level after edge %0d from release: got %b want %b",
                         j, bif.switch_level[0], (j >= 6));
            end
        end
        settle();
    endtask

    task automatic test_random();
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if (bif.switch_level !== m_sw) begin
                errors++;
                $display("FAIL random_level cycle %0d: got %b want %b", i, bif.switch_level, m_sw);
            end
            checks++;
            if (bif.press_pulse !== m_press) begin
                errors++;
                $display("FAIL random_press cycle %0d: got %b want %b", i, bif.press_pulse, m_press);
            end
            checks++;
            if (bif.release_pulse !== m_rel) begin
                errors++;
                $display("FAIL random_release cycle %0d: got %b want %b", i, bif.release_pulse, m_rel);
            end
            checks++;
            if ((bif.press_pulse & bif.release_pulse) !== '0) begin
                errors++;
                $display("FAIL random_exclusive cycle %0d: press %b release %b overlap",
                         i, bif.press_pulse, bif.release_pulse);
            end
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({bif.switch_level, bif.press_pulse, bif.release_pulse} !== 12'h000) begin
                    errors++;
                    $display("FAIL random_reset_clear cycle %0d: got %h want 000", i,
                             {bif.switch_level, bif.press_pulse, bif.release_pulse});
                end
                @(negedge clk);
                rst = 1'b0;
            end
        end
        settle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        raw    = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release_parallel();
        test_reset_midqual();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
